// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and defaults for the program-counter sequencer.
// Optional build macro used by this slice: PC_SEQ_PERF_EN.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2
  } sel_t;

  localparam int DEF_STEP       = 4;
  localparam int DEF_ALIGN_BITS = 2;

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-side valid/ready handshake carrying the PC.
// master = sequencer, slave = fetch stage.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] pc;
  logic             pc_valid;
  logic             pc_ready;
  logic [WIDTH-1:0] pc_plus_step;

  modport master (
    output pc,
    output pc_valid,
    output pc_plus_step,
    input  pc_ready
  );

  modport slave (
    input  pc,
    input  pc_valid,
    input  pc_plus_step,
    output pc_ready
  );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC mux (jump > branch > sequential) with
// target alignment masking and misalignment detection.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STEP       = DEF_STEP,
  parameter int ALIGN_BITS = DEF_ALIGN_BITS
) (
  input  logic [WIDTH-1:0] pc,
  input  logic             advance,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  output sel_t             sel,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             misalign
);

  localparam logic [WIDTH-1:0] AMASK =
    WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [WIDTH-1:0] tgt;

  assign pc_plus_step = pc + WIDTH'(STEP);

  // fixed redirect priority
  always_comb begin
    sel = SEL_SEQ;
    if (jump_en)
      sel = SEL_JUMP;
    else if (branch_taken)
      sel = SEL_BRANCH;
  end

  // target pick, low-bit masking and next pc
  always_comb begin
    tgt      = '0;
    pc_next  = pc;
    misalign = 1'b0;
    unique case (sel)
      SEL_JUMP:   tgt = jump_target;
      SEL_BRANCH: tgt = branch_target;
      default:    tgt = '0;
    endcase
    if (sel != SEL_SEQ) begin
      pc_next  = tgt & ~AMASK;
      misalign = |(tgt & AMASK);
    end else if (advance) begin
      pc_next  = pc_plus_step;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch PC register, BOOT/RUN/HALT control, sticky
// misalign flag; PC_SEQ_PERF_EN adds fetch/redirect counters.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int          WIDTH        = 32,
  parameter int          STEP         = DEF_STEP,
  parameter int          ALIGN_BITS   = DEF_ALIGN_BITS,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  pc_sequencer_if.master   fetch,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             err_clr,
  output logic             halted,
  output logic             misalign_err
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [31:0]      fetch_cnt,
  output logic [31:0]      redirect_cnt
`endif
);

  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_VECTOR);

  state_t           state_q, state_d;
  logic             boot_q;
  logic [WIDTH-1:0] pc_q, pc_next, pc_plus_step;
  logic             accept, misalign, redirect;
  sel_t             sel;

  assign accept   = (state_q == RUN) & fetch.pc_ready & ~stall;
  assign redirect = (sel != SEL_SEQ);

  pc_next_sel #(
    .WIDTH      (WIDTH),
    .STEP       (STEP),
    .ALIGN_BITS (ALIGN_BITS)
  ) u_sel (
    .pc            (pc_q),
    .advance       (accept),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .sel           (sel),
    .pc_next       (pc_next),
    .pc_plus_step  (pc_plus_step),
    .misalign      (misalign)
  );

  // state, pc and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      boot_q       <= 1'b0;
      pc_q         <= RST_PC;
      misalign_err <= 1'b0;
    end else begin
      state_q <= state_d;
      boot_q  <= 1'b1;
      pc_q    <= pc_next;
      if (misalign)
        misalign_err <= 1'b1;
      else if (err_clr)
        misalign_err <= 1'b0;
    end
  end

  // BOOT waits one full cycle after the first edge out of reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: if (boot_q) state_d = halt_req ? HALT : RUN;
      RUN:  if (halt_req) state_d = HALT;
      HALT: if (!halt_req) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  assign fetch.pc           = pc_q;
  assign fetch.pc_valid     = (state_q == RUN);
  assign fetch.pc_plus_step = pc_plus_step;
  assign halted             = (state_q == HALT);

`ifdef PC_SEQ_PERF_EN
  // handshake and redirect event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else if (err_clr) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (accept)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (redirect)
        redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule
